eth_tx_frame_ctrl: RTL and testbench

// Ethernet MAC TX frame sequencer. Takes one frame from a byte-wide AXI-Stream and drives a GMII-style byte output.

---
 rtl/eth_tx_frame_ctrl_if.sv | 10 +
 rtl/eth_tx_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_eth_tx_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_frame_ctrl_if.sv
// Byte-wide AXI-Stream link from the TX FIFO into the frame sequencer.
interface eth_tx_frame_ctrl_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_frame_ctrl.sv
// Ethernet MAC TX frame sequencer: preamble/SFD, payload, zero pad, FCS and
// inter-frame gap onto a registered GMII byte interface.
module eth_tx_frame_ctrl #(
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514,
    parameter int IFG_BYTES   = 12
) (
    input  logic                aclk,
    input  logic                aresetn,
    eth_tx_frame_ctrl_if.slave  s_axis,
    output logic                psfd_start,
    input  logic                psfd_done,
    input  logic [7:0]          psfd_data,
    output logic                crc_init,
    output logic                crc_en,
    output logic [7:0]          crc_din,
    input  logic [31:0]         crc_in,
    output logic [7:0]          gmii_txd,
    output logic                gmii_tx_en,
    output logic                gmii_tx_er,
    output logic                tx_busy,
    output logic                frame_done,
    output logic                tx_err
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int IW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PAYLOAD);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_PAYLOAD);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG, DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    pre_cnt, pre_cnt_nxt;
    logic [CW-1:0] byte_cnt, byte_cnt_nxt, byte_inc;
    logic [1:0]    fcs_cnt, fcs_cnt_nxt;
    logic [IW-1:0] ifg_cnt, ifg_cnt_nxt;
    logic          psfd_check, psfd_check_nxt;
    logic [31:0]   fcs_reg, fcs_reg_nxt;
    logic [7:0]    sel_txd;
    logic          sel_en, sel_er;
    logic          ready;

    assign byte_inc      = byte_cnt + CW'(1);
    assign s_axis.tready = ready;

    // Next-state and output decode; everything stays 0 while reset is held.
    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        byte_cnt_nxt   = byte_cnt;
        fcs_cnt_nxt    = fcs_cnt;
        ifg_cnt_nxt    = ifg_cnt;
        psfd_check_nxt = 1'b0;
        fcs_reg_nxt    = fcs_reg;
        ready          = 1'b0;
        psfd_start     = 1'b0;
        crc_init       = 1'b0;
        crc_en         = 1'b0;
        crc_din        = 8'h00;
        frame_done     = 1'b0;
        tx_err         = 1'b0;
        tx_busy        = 1'b0;
        sel_txd        = 8'h00;
        sel_en         = 1'b0;
        sel_er         = 1'b0;
        if (aresetn) begin
            tx_busy = (state != IDLE);
            case (state)
                IDLE: begin
                    byte_cnt_nxt = '0;
                    if (s_axis.tvalid) begin
                        psfd_start = 1'b1;
                        crc_init   = 1'b1;
                        state_nxt  = PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    sel_txd     = psfd_data;
                    sel_en      = 1'b1;
                    pre_cnt_nxt = pre_cnt + 3'd1;
                    if (pre_cnt == 3'd7) begin
                        psfd_check_nxt = 1'b1;
                        state_nxt      = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // A generator that has not finished, or a frame that hit the
                    // size limit, aborts without accepting the byte on offer so
                    // that no tlast can slip past the drain logic.
                    if (psfd_check && !psfd_done) begin
                        sel_en    = 1'b1;
                        sel_er    = 1'b1;
                        tx_err    = 1'b1;
                        state_nxt = IFG;
                    end else if (byte_cnt == MAX_C) begin
                        sel_en    = 1'b1;
                        sel_er    = 1'b1;
                        tx_err    = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        ready = 1'b1;
                        if (s_axis.tvalid) begin
                            sel_txd      = s_axis.tdata;
                            sel_en       = 1'b1;
                            crc_en       = 1'b1;
                            crc_din      = s_axis.tdata;
                            byte_cnt_nxt = byte_inc;
                            if (s_axis.tlast)
                                state_nxt = (byte_inc < MIN_C) ? PAD : FCS;
                        end else begin
                            sel_en    = 1'b1;
                            sel_er    = 1'b1;
                            tx_err    = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end
                end
                PAD: begin
                    sel_en       = 1'b1;
                    crc_en       = 1'b1;
                    byte_cnt_nxt = byte_inc;
                    if (byte_inc == MIN_C)
                        state_nxt = FCS;
                end
                FCS: begin
                    sel_en      = 1'b1;
                    fcs_cnt_nxt = fcs_cnt + 2'd1;
                    if (fcs_cnt == 2'd0) begin
                        sel_txd     = crc_in[7:0];
                        fcs_reg_nxt = crc_in;
                    end else begin
                        sel_txd = fcs_reg[{fcs_cnt, 3'b000} +: 8];
                    end
                    if (fcs_cnt == 2'd3) begin
                        frame_done = 1'b1;
                        state_nxt  = IFG;
                    end
                end
                IFG: begin
                    ifg_cnt_nxt = ifg_cnt + IW'(1);
                    if (ifg_cnt == IFG_LAST) begin
                        ifg_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end
                end
                DRAIN: begin
                    ready = 1'b1;
                    if (s_axis.tvalid && s_axis.tlast)
                        state_nxt = IFG;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            byte_cnt   <= '0;
            fcs_cnt    <= '0;
            ifg_cnt    <= '0;
            psfd_check <= 1'b0;
            fcs_reg    <= '0;
        end else begin
            state      <= state_nxt;
            pre_cnt    <= pre_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            fcs_cnt    <= fcs_cnt_nxt;
            ifg_cnt    <= ifg_cnt_nxt;
            psfd_check <= psfd_check_nxt;
            fcs_reg    <= fcs_reg_nxt;
        end
    end

    // GMII outputs are registered: the byte selected this cycle goes out next cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
        end else begin
            gmii_txd   <= sel_txd;
            gmii_tx_en <= sel_en;
            gmii_tx_er <= sel_er;
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Self-checking bench for eth_tx_frame_ctrl: table of frame scenarios with
// random payload data, plus reset sequences, against a frame-level model.
module tb_eth_tx_frame_ctrl;
    localparam int MIN_PAYLOAD = 60;
    localparam int MAX_PAYLOAD = 1514;
    localparam int IFG_BYTES   = 12;

    typedef struct {
        string name;
        int    len;
        int    nframes;
        int    stall_after;
        bit    psfd_fail;
        int    exp_en;
        int    exp_er;
        int    exp_done;
        int    exp_err;
        int    exp_crc;
        int    exp_rise;
        int    exp_gap;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        psfd_start, psfd_done, crc_init, crc_en;
    logic [7:0]  psfd_data, crc_din, gmii_txd;
    logic [31:0] crc_in;
    logic        gmii_tx_en, gmii_tx_er, tx_busy, frame_done, tx_err;
    int          compared = 0;
    int          mismatched = 0;

    eth_tx_frame_ctrl_if s_if ();

    eth_tx_frame_ctrl #(
        .MIN_PAYLOAD(MIN_PAYLOAD),
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .IFG_BYTES  (IFG_BYTES)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .psfd_start(psfd_start),
        .psfd_done (psfd_done),
        .psfd_data (psfd_data),
        .crc_init  (crc_init),
        .crc_en    (crc_en),
        .crc_din   (crc_din),
        .crc_in    (crc_in),
        .gmii_txd  (gmii_txd),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er),
        .tx_busy   (tx_busy),
        .frame_done(frame_done),
        .tx_err    (tx_err)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // External CRC-32 engine: result valid the cycle after its last enable.
    logic [31:0] crc_state = 32'hFFFFFFFF;
    always @(posedge aclk) begin
        if (crc_init)    crc_state <= 32'hFFFFFFFF;
        else if (crc_en) crc_state <= crcByte(crc_state, crc_din);
    end
    assign crc_in = ~crc_state;

    // Preamble/SFD generator: 7x55 then D5 in the 8 cycles after start, then done.
    int gen_cnt = 0;
    int start_num = 0;
    int fail_on_start = -1;
    always @(posedge aclk) begin
        if (psfd_start) begin
            gen_cnt   <= 1;
            start_num <= start_num + 1;
        end else if (gen_cnt >= 1 && gen_cnt <= 8) begin
            gen_cnt <= gen_cnt + 1;
        end
    end
    assign psfd_data = (gen_cnt == 8) ? 8'hD5 : 8'h55;
    assign psfd_done = (gen_cnt == 9) && (start_num != fail_on_start);

    // Line monitor: cumulative record of GMII bytes and event pulses.
    logic [8:0] obs_q[$];
    int   en_cnt = 0, er_cnt = 0, done_cnt = 0, err_cnt = 0, crcen_cnt = 0;
    int   rise_cnt = 0, low_run = 0, last_gap = 0;
    logic prev_en = 1'b0;
    always @(negedge aclk) begin
        if (gmii_tx_en || gmii_tx_er) obs_q.push_back({gmii_tx_er, gmii_txd});
        if (gmii_tx_en) en_cnt++;
        if (gmii_tx_er) er_cnt++;
        if (frame_done) done_cnt++;
        if (tx_err)     err_cnt++;
        if (crc_en)     crcen_cnt++;
        if (gmii_tx_en && !prev_en) begin
            rise_cnt++;
            last_gap = low_run;
        end
        low_run = gmii_tx_en ? 0 : low_run + 1;
        prev_en = gmii_tx_en;
    end

    logic [8:0] src_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];

    function automatic int outWord();
        return int'({s_if.tready, psfd_start, crc_init, crc_en, crc_din, gmii_txd,
                     gmii_tx_en, gmii_tx_er, tx_busy, frame_done, tx_err});
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic genFrame(input int len);
        logic [7:0] b;
        pay_q.delete();
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            pay_q.push_back(b);
            src_q.push_back({(i == len - 1), b});
        end
    endtask

    task automatic pushPreamble();
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
    endtask

    // Expected line bytes for one frame, derived from the framing rules.
    task automatic modelFrame(input int len, input int stall_after, input bit psfd_fail);
        logic [7:0]  body[$];
        logic [31:0] c;
        if (psfd_fail) begin
            pushPreamble();
            exp_q.push_back(9'h100);
        end
        pushPreamble();
        if (stall_after >= 0 && stall_after < len) begin
            for (int i = 0; i < stall_after; i++) exp_q.push_back({1'b0, pay_q[i]});
            exp_q.push_back(9'h100);
        end else if (len > MAX_PAYLOAD) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) exp_q.push_back({1'b0, pay_q[i]});
            exp_q.push_back(9'h100);
        end else begin
            body = pay_q;
            while (body.size() < MIN_PAYLOAD) body.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (body[i]) c = crcByte(c, body[i]);
            c = ~c;
            foreach (body[i]) exp_q.push_back({1'b0, body[i]});
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
        end
    endtask

    // Drives the queued stream; optionally drops tvalid for 3 cycles after a byte count.
    task automatic applyStimulus(input int stall_after);
        int   sent = 0;
        int   cyc = 0;
        bit   stalled = 1'b0;
        logic hs;
        while (src_q.size() > 0 && cyc < 4000) begin
            if (sent == stall_after && !stalled) begin
                s_if.tvalid = 1'b0;
                stalled = 1'b1;
                repeat (3) @(posedge aclk);
                #1;
                cyc += 3;
            end else begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = src_q[0][7:0];
                s_if.tlast  = src_q[0][8];
                @(negedge aclk);
                hs = s_if.tready;
                @(posedge aclk);
                #1;
                cyc++;
                if (hs) begin
                    void'(src_q.pop_front());
                    sent++;
                end
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = 8'h00;
    endtask

    task automatic runCase(input vec_t v);
        int base_obs  = obs_q.size();
        int base_en   = en_cnt;
        int base_er   = er_cnt;
        int base_done = done_cnt;
        int base_err  = err_cnt;
        int base_crc  = crcen_cnt;
        int base_rise = rise_cnt;
        int bad = -1;
        int w = 0;
        exp_q.delete();
        if (v.psfd_fail) fail_on_start = start_num + 1;
        for (int f = 0; f < v.nframes; f++) begin
            genFrame(v.len);
            modelFrame(v.len, v.stall_after, v.psfd_fail);
        end
        @(posedge aclk);
        #1;
        applyStimulus(v.stall_after);
        checkOutput({v.name, " src_drained"}, src_q.size(), 0);
        src_q.delete();
        @(negedge aclk);
        while (tx_busy && w < 400) begin
            @(negedge aclk);
            w++;
        end
        checkOutput({v.name, " back_to_idle"}, int'(tx_busy), 0);
        repeat (3) @(negedge aclk);
        #1;
        checkOutput({v.name, " tx_en_bytes"}, en_cnt - base_en, v.exp_en);
        checkOutput({v.name, " tx_er_bytes"}, er_cnt - base_er, v.exp_er);
        checkOutput({v.name, " frame_done"}, done_cnt - base_done, v.exp_done);
        checkOutput({v.name, " tx_err"}, err_cnt - base_err, v.exp_err);
        checkOutput({v.name, " crc_en_cycles"}, crcen_cnt - base_crc, v.exp_crc);
        checkOutput({v.name, " tx_en_bursts"}, rise_cnt - base_rise, v.exp_rise);
        if (v.exp_gap > 0) checkOutput({v.name, " ifg_gap"}, last_gap, v.exp_gap);
        checkOutput({v.name, " stream_len"}, obs_q.size() - base_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && bad < 0; i++)
            if (base_obs + i >= obs_q.size() || obs_q[base_obs + i] !== exp_q[i]) bad = i;
        if (bad >= 0 && base_obs + bad < obs_q.size())
            $display("[TB]   %s byte %0d: got %03h exp %03h", v.name, bad,
                     obs_q[base_obs + bad], exp_q[bad]);
        checkOutput({v.name, " stream_first_diff"}, bad, -1);
        fail_on_start = -1;
    endtask

    // Bounded run time: never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t rv;
        int   l;
        //        name          len   nfr stall fail  en    er done err crc   rise gap
        tbl[0] = '{"min60",      60,   1,  -1,  1'b0, 72,   0, 1,   0, 60,   1,   0};
        tbl[1] = '{"short10",    10,   1,  -1,  1'b0, 72,   0, 1,   0, 60,   1,   0};
        tbl[2] = '{"len59",      59,   1,  -1,  1'b0, 72,   0, 1,   0, 60,   1,   0};
        tbl[3] = '{"len61",      61,   1,  -1,  1'b0, 73,   0, 1,   0, 61,   1,   0};
        tbl[4] = '{"b2b100",     100,  2,  -1,  1'b0, 224,  0, 2,   0, 200,  2,   13};
        tbl[5] = '{"underrun",   100,  1,  20,  1'b0, 29,   1, 0,   1, 20,   1,   0};
        tbl[6] = '{"max1514",    1514, 1,  -1,  1'b0, 1526, 0, 1,   0, 1514, 1,   0};
        tbl[7] = '{"over1600",   1600, 1,  -1,  1'b0, 1523, 1, 0,   1, 1514, 1,   0};
        tbl[8] = '{"psfd_fail",  60,   1,  -1,  1'b1, 81,   1, 1,   1, 60,   2,   13};

        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hA5;
        s_if.tlast  = 1'b0;
        aresetn     = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_outputs", outWord(), 0);
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("idle_outputs", outWord(), 0);

        for (int i = 0; i < 9; i++) runCase(tbl[i]);

        for (int r = 0; r < 4; r++) begin
            l = $urandom_range(1, 130);
            rv.name = $sformatf("rand%0d_len%0d", r, l);
            rv.len = l;
            rv.nframes = 1;
            rv.stall_after = -1;
            rv.psfd_fail = 1'b0;
            rv.exp_en = 8 + ((l < MIN_PAYLOAD) ? MIN_PAYLOAD : l) + 4;
            rv.exp_er = 0;
            rv.exp_done = 1;
            rv.exp_err = 0;
            rv.exp_crc = (l < MIN_PAYLOAD) ? MIN_PAYLOAD : l;
            rv.exp_rise = 1;
            rv.exp_gap = 0;
            runCase(rv);
        end

        // Reset in the middle of a payload, then a clean frame.
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            s_if.tdata = 8'(i);
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        checkOutput("busy_before_reset", int'(tx_busy), 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_mid_outputs", outWord(), 0);
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tbl[0].name = "after_reset";
        runCase(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
